// File: rtl/ntt_pkg.sv
// Shared defaults and FSM encodings for the NTT output serializer.
package ntt_pkg;

    localparam int NTT_DW   = 28;
    localparam int NTT_IPC  = 32;
    localparam int NTT_N    = 1024;
    localparam int NTT_VECS = NTT_N / NTT_IPC;

    typedef logic [NTT_DW-1:0] coef_t;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_FILL  = 2'd1;
    localparam logic [1:0] W_SKIP  = 2'd2;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_DRAIN = 1'b1;

endpackage

// File: rtl/ntt_ser_bank.sv
// One polynomial buffer bank: full-vector write port, single-coefficient async read port.
module ntt_ser_bank
    import ntt_pkg::*;
#(
    parameter int DW   = NTT_DW,
    parameter int IPC  = NTT_IPC,
    parameter int VECS = NTT_VECS
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(VECS)-1:0]       wr_vec,
    input  logic [IPC-1:0][DW-1:0]        wr_data,
    input  logic [$clog2(VECS)-1:0]       rd_vec,
    input  logic [$clog2(IPC)-1:0]        rd_lane,
    output logic [DW-1:0]                 rd_data
);

    logic [IPC-1:0][DW-1:0] mem [VECS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_vec] <= wr_data;
    end

    assign rd_data = mem[rd_vec][rd_lane];

endmodule

// File: rtl/ntt_out_serializer.sv
// Ping-pong buffer turning NTT core output vectors into a valid/ready coefficient stream.
// Build option NTT_OUT_SER_BITREV_EN: drain each frame in bit-reversed coefficient order.
//
// state   | meaning
// W_IDLE  | waiting for out_start
// W_FILL  | writing vectors 1..VECS-1 into bank wr_sel
// W_SKIP  | no free bank, letting the dropped frame pass
// R_IDLE  | output empty, waiting for full[rd_sel]
// R_DRAIN | output register holds coefficient rcnt of bank rd_sel
module ntt_out_serializer
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = NTT_DW,
    parameter int INPUT_PER_CYCLE      = NTT_IPC,
    parameter int N                    = NTT_N
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                out_start,
    input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] outData,
    output logic                                                m_valid,
    input  logic                                                m_ready,
    output logic [DATA_WIDTH_PER_INPUT-1:0]                     m_data,
    output logic                                                m_last,
    output logic                                                overflow,
    output logic                                                frame_err
);

    localparam int VECS    = N / INPUT_PER_CYCLE;
    localparam int VEC_W   = $clog2(VECS);
    localparam int LOG2N   = $clog2(N);
    localparam int LOG2IPC = $clog2(INPUT_PER_CYCLE);
    localparam logic [VEC_W-1:0] WLAST   = VEC_W'(VECS - 1);
    localparam logic [LOG2N-1:0] LAST    = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] LAST_M1 = LOG2N'(N - 2);

    logic [1:0]       wstate;
    logic [0:0]       rstate;
    logic             wr_sel, rd_sel;
    logic [1:0]       full;
    logic [VEC_W-1:0] wcnt;
    logic [LOG2N-1:0] rcnt;

    logic             wr_en, set_full, clr_full, rd_bank;
    logic [VEC_W-1:0] wr_vec;
    logic [LOG2N-1:0] rd_idx, rd_addr;
    logic [1:0][DATA_WIDTH_PER_INPUT-1:0] bank_q;
    logic [DATA_WIDTH_PER_INPUT-1:0]      rd_data;

    always_comb begin
        wr_en  = 1'b0;
        wr_vec = wcnt;
        if (wstate == W_IDLE) begin
            wr_vec = '0;
            wr_en  = out_start && !full[wr_sel];
        end else if (wstate == W_FILL) begin
            wr_en  = 1'b1;
        end
    end

    assign set_full = (wstate == W_FILL) && (wcnt == WLAST);
    assign clr_full = (rstate == R_DRAIN) && m_ready && (rcnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate    <= W_IDLE;
            wcnt      <= '0;
            wr_sel    <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (out_start) begin
                        wcnt <= VEC_W'(1);
                        if (!full[wr_sel]) begin
                            wstate <= W_FILL;
                        end else begin
                            wstate   <= W_SKIP;
                            overflow <= 1'b1;
                        end
                    end
                end
                W_FILL, W_SKIP: begin
                    if (out_start) frame_err <= 1'b1;
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == WLAST) begin
                        wstate <= W_IDLE;
                        if (wstate == W_FILL) wr_sel <= ~wr_sel;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Set and clear always target different banks, so both land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (set_full) full[wr_sel] <= 1'b1;
            if (clr_full) full[rd_sel] <= 1'b0;
        end
    end

    // Next coefficient to load; on the last accept, look ahead into the other bank.
    always_comb begin
        rd_bank = rd_sel;
        rd_idx  = rcnt + 1'b1;
        if (rstate == R_IDLE) begin
            rd_idx = '0;
        end else if (rcnt == LAST) begin
            rd_bank = ~rd_sel;
            rd_idx  = '0;
        end
    end

    always_comb begin
        rd_addr = '0;
`ifdef NTT_OUT_SER_BITREV_EN
        for (int b = 0; b < LOG2N; b++) rd_addr[b] = rd_idx[LOG2N-1-b];
`else
        rd_addr = rd_idx;
`endif
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        ntt_ser_bank #(
            .DW   (DATA_WIDTH_PER_INPUT),
            .IPC  (INPUT_PER_CYCLE),
            .VECS (VECS)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_en && (wr_sel == 1'(g))),
            .wr_vec  (wr_vec),
            .wr_data (outData),
            .rd_vec  (rd_addr[LOG2N-1:LOG2IPC]),
            .rd_lane (rd_addr[LOG2IPC-1:0]),
            .rd_data (bank_q[g])
        );
    end

    assign rd_data = bank_q[rd_bank];

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate  <= R_IDLE;
            rcnt    <= '0;
            rd_sel  <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (full[rd_sel]) begin
                        rstate  <= R_DRAIN;
                        rcnt    <= '0;
                        m_valid <= 1'b1;
                        m_data  <= rd_data;
                        m_last  <= 1'b0;
                    end
                end
                R_DRAIN: begin
                    if (m_ready) begin
                        if (rcnt == LAST) begin
                            rd_sel <= ~rd_sel;
                            rcnt   <= '0;
                            m_last <= 1'b0;
                            if (full[~rd_sel]) begin
                                m_data <= rd_data;
                            end else begin
                                m_valid <= 1'b0;
                                rstate  <= R_IDLE;
                            end
                        end else begin
                            rcnt   <= rcnt + 1'b1;
                            m_data <= rd_data;
                            m_last <= (rcnt == LAST_M1);
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_out_serializer.sv
// Scenario-table bench for ntt_out_serializer with a frame-queue reference model.
module tb_ntt_out_serializer;
    import ntt_pkg::*;

    localparam int DW      = NTT_DW;
    localparam int IPC     = NTT_IPC;
    localparam int NN      = NTT_N;
    localparam int VECS    = NTT_VECS;
    localparam int LOG2N   = $clog2(NN);
    localparam int TIMEOUT = 9000;

    typedef struct {
        int nfr; int gap; int dmode; int rmode; int rdelay; int ferr_at;
        bit exp_ovf; bit exp_ferr; int exp_frames; int exp_lat; int exp_span;
    } scen_t;

    logic clk = 1'b0, rst = 1'b1, out_start = 1'b0, m_ready = 1'b0;
    logic [IPC-1:0][DW-1:0] outData = '0;
    logic m_valid, m_last, overflow, frame_err;
    logic [DW-1:0] m_data;

    ntt_out_serializer dut (
        .clk(clk), .rst(rst), .out_start(out_start), .outData(outData),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    scen_t tab[7];
    coef_t cur[NN];
    int cap_vec = -1;
    // reference model: frames as flat queues of output-order values plus an occupancy count
    coef_t expq[$];
    int mcap = 0, mfull = 0, opos = 0;
    bit mdrop = 0, eov = 0, efe = 0;
    int acc_total = 0, frames_out = 0, first_valid = -1, last_acc = -1;
    bit pv = 0, pr = 0, pl = 0;
    coef_t pd = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) if (v[b]) r |= 1 << (LOG2N - 1 - b);
        return r;
    endfunction

    function automatic logic rdy(input int mode, input int dly, input int t);
        if (t < dly) return 1'b0;
        case (mode)
            0: return 1'b1;
            1: return (t % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic start_frame(input int dmode);
        for (int k = 0; k < NN; k++) begin
            case (dmode)
                0: cur[k] = coef_t'(k + 1);
                1: cur[k] = coef_t'(k);
                default: cur[k] = coef_t'($urandom);
            endcase
        end
        cap_vec   = 0;
        out_start = 1'b1;
    endtask

    task automatic model();
        coef_t e;
        if (rst) begin
            mcap = 0; mfull = 0; opos = 0; mdrop = 0; eov = 0; efe = 0; pv = 0;
            expq.delete();
            return;
        end
        if (pv && !pr) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, pd);
            check("hold_last", m_last, pl);
        end
        check("flag_overflow", overflow, eov);
        check("flag_frame_err", frame_err, efe);
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (mcap == 0) begin
            if (out_start) begin
                mdrop = (mfull >= 2);
                if (mdrop) eov = 1;
                mcap = VECS;
            end
        end else if (out_start) begin
            efe = 1;
        end
        if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got data %0d, required no beat (cycle %0d)", m_data, cyc);
            end else begin
                e = expq.pop_front();
                check("data", m_data, e);
            end
            check("last", m_last, opos == NN - 1);
            if (opos == NN - 1) begin opos = 0; mfull--; frames_out++; end
            else opos++;
            acc_total++;
            last_acc = cyc;
        end
        if (mcap > 0) begin
            mcap--;
            if (mcap == 0 && !mdrop) begin
                for (int i = 0; i < NN; i++) begin
`ifdef NTT_OUT_SER_BITREV_EN
                    expq.push_back(cur[brev(i)]);
`else
                    expq.push_back(cur[i]);
`endif
                end
                mfull++;
            end
        end
        pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        out_start = 1'b0;
        if (cap_vec >= 0 && cap_vec < VECS - 1) cap_vec++;
        else cap_vec = -1;
    endtask

    task automatic end_cycle();
        for (int l = 0; l < IPC; l++)
            outData[l] = (cap_vec >= 0) ? cur[cap_vec * IPC + l] : coef_t'($urandom);
        @(negedge clk);
        model();
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            begin_cycle();
            rst = 1'b1;
            m_ready = 1'b0;
            end_cycle();
        end
    endtask

    task automatic run_scen(input scen_t s, input int idx, input bit with_reset);
        int t, fr, c0;
        if (with_reset) do_reset(2);
        first_valid = -1; last_acc = -1; frames_out = 0; acc_total = 0;
        t = 0; fr = 0; c0 = cyc + 1;
        while (1) begin
            begin_cycle();
            if (fr < s.nfr && t == fr * s.gap) begin
                if (fr == 0) c0 = cyc;
                start_frame(s.dmode);
                fr++;
            end
            if (t == s.ferr_at) out_start = 1'b1;
            m_ready = rdy(s.rmode, s.rdelay, t);
            end_cycle();
            t++;
            if (fr == s.nfr && cap_vec < 0 && mcap == 0 && expq.size() == 0 && t > 2) break;
            if (t >= TIMEOUT) begin
                checks++; errors++;
                $display("FAIL timeout_scen%0d: beats outstanding %0d, required 0", idx, expq.size());
                break;
            end
        end
        repeat (5) begin
            begin_cycle();
            m_ready = 1'b1;
            end_cycle();
        end
        check($sformatf("s%0d_idle_valid", idx), m_valid, 0);
        check($sformatf("s%0d_overflow", idx), overflow, s.exp_ovf);
        check($sformatf("s%0d_frame_err", idx), frame_err, s.exp_ferr);
        check($sformatf("s%0d_frames", idx), frames_out, s.exp_frames);
        check($sformatf("s%0d_latency", idx), first_valid - c0, s.exp_lat);
        if (s.exp_span > 0)
            check($sformatf("s%0d_span", idx), last_acc - first_valid + 1, s.exp_span);
    endtask

    initial begin
        int t;
        //           nfr gap  dm rm rdly ferr  ovf   ferr  frm lat span
        tab[0] = '{1,  0,   0, 0, 0,   -1, 1'b0, 1'b0, 1, 33, 1024};
        tab[1] = '{1,  0,   0, 1, 0,   -1, 1'b0, 1'b0, 1, 33, -1};
        tab[2] = '{3,  32,  2, 0, 200, -1, 1'b1, 1'b0, 2, 33, -1};
        tab[3] = '{1,  0,   2, 2, 0,   5,  1'b0, 1'b1, 1, 33, -1};
        tab[4] = '{2,  32,  2, 2, 0,   -1, 1'b0, 1'b0, 2, 33, -1};
        tab[5] = '{3,  600, 2, 0, 0,   -1, 1'b0, 1'b0, 3, 33, -1};
        tab[6] = '{3,  32,  1, 0, 0,   -1, 1'b1, 1'b0, 2, 33, 2048};

        do_reset(3);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);

        for (int i = 0; i < 7; i++) run_scen(tab[i], i, 1'b1);

        // reset in the middle of a drain, then a fresh frame without another reset
        do_reset(2);
        acc_total = 0;
        t = 0;
        while (acc_total < 500 && t < TIMEOUT) begin
            begin_cycle();
            if (t == 0) start_frame(2);
            m_ready = 1'b1;
            end_cycle();
            t++;
        end
        if (acc_total < 500) begin
            checks++; errors++;
            $display("FAIL timeout_middrain: got %0d beats, required 500", acc_total);
        end
        begin_cycle();
        rst = 1'b1;
        m_ready = 1'b1;
        end_cycle();
        begin_cycle();
        m_ready = 1'b1;
        end_cycle();
        check("middrain_valid", m_valid, 0);
        check("middrain_last", m_last, 0);
        check("middrain_data", m_data, 0);
        check("middrain_overflow", overflow, 0);
        check("middrain_frame_err", frame_err, 0);
        run_scen(tab[0], 7, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
